// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Multi-cycle sequencer for register-specified shifts
//            (LSL/LSR/ASR/ROR by Rs). A 1-bit-per-cycle shift register
//            and a step counter replace a full barrel shifter. Valid/ready
//            handshakes are used on both the request and result sides.
// Ports    : clk, reset, flush          - clock, sync reset, sync abort
//            in_valid/in_ready          - request handshake (ready in IDLE)
//            shift_control, Rm, Rs, c_in - op, operand, amount, carry in
//            out_valid/out_ready        - result handshake (valid in DONE)
//            Rd, ShifterFlags           - result and {N,Z,C,V}
//            busy                       - sequencer not idle
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter int WIDTH    = 32,
  parameter int AMT_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          shift_control,
  input  logic [WIDTH-1:0]    Rm,
  input  logic [AMT_BITS-1:0] Rs,
  input  logic                c_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    Rd,
  output logic [3:0]          ShifterFlags,
  output logic                busy
);

  localparam int LOG_W = $clog2(WIDTH);
  // Counter must hold WIDTH+1 steps (logical shifts by more than WIDTH).
  localparam int CNT_W = $clog2(WIDTH + 2);

  localparam logic [31:0] MAX_LOGICAL = 32'(WIDTH + 1);
  localparam logic [31:0] MAX_ARITH   = 32'(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_q;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rd_q;
  logic [3:0]       flags_q;

  logic [31:0]      w_amt;
  logic [CNT_W-1:0] w_steps;
  logic             w_zero_c;
  logic [WIDTH-1:0] w_step_sh;
  logic             w_step_c;
  logic             w_accept;
  logic             w_last_step;

  assign w_amt       = 32'(Rs);
  assign w_accept    = (state_q == S_IDLE) && in_valid;
  assign w_last_step = (state_q == S_BUSY) && (cnt_q == CNT_W'(1));

  // --------------------------------------------------------------------------
  // Step count and carry for the zero-step cases, decided at accept time.
  // Logical shifts run one step past WIDTH so the carry naturally becomes 0.
  // --------------------------------------------------------------------------
  always_comb begin
    w_steps  = '0;
    w_zero_c = c_in;
    if (w_amt != 32'd0) begin
      case (shift_control)
        OP_LSL, OP_LSR: w_steps = CNT_W'((w_amt > MAX_LOGICAL) ? MAX_LOGICAL : w_amt);
        OP_ASR:         w_steps = CNT_W'((w_amt > MAX_ARITH) ? MAX_ARITH : w_amt);
        default: begin
          // Rotation by a multiple of WIDTH leaves Rm intact; C is its MSB.
          w_steps  = CNT_W'(w_amt[LOG_W-1:0]);
          w_zero_c = Rm[WIDTH-1];
        end
      endcase
    end
  end

  // One shift/rotate step of the working register.
  always_comb begin
    w_step_sh = sh_q;
    w_step_c  = 1'b0;
    case (op_q)
      OP_LSL: begin
        w_step_sh = {sh_q[WIDTH-2:0], 1'b0};
        w_step_c  = sh_q[WIDTH-1];
      end
      OP_LSR: begin
        w_step_sh = {1'b0, sh_q[WIDTH-1:1]};
        w_step_c  = sh_q[0];
      end
      OP_ASR: begin
        w_step_sh = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
        w_step_c  = sh_q[0];
      end
      OP_ROR: begin
        w_step_sh = {sh_q[0], sh_q[WIDTH-1:1]};
        w_step_c  = sh_q[0];
      end
      default: begin
        w_step_sh = sh_q;
        w_step_c  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = (w_steps == '0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_DONE:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath. The working register sh_q shifts during BUSY; the visible
  // result rd_q/flags_q is only written on DONE entry so it stays stable.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      sh_q    <= '0;
      op_q    <= OP_LSL;
      cnt_q   <= '0;
      rd_q    <= '0;
      flags_q <= '0;
    end else if (w_accept) begin
      sh_q  <= Rm;
      op_q  <= shift_control;
      cnt_q <= w_steps;
      if (w_steps == '0) begin
        rd_q    <= Rm;
        flags_q <= {Rm[WIDTH-1], (Rm == '0), w_zero_c, 1'b0};
      end
    end else if (state_q == S_BUSY) begin
      sh_q  <= w_step_sh;
      cnt_q <= cnt_q - CNT_W'(1);
      if (w_last_step) begin
        rd_q    <= w_step_sh;
        flags_q <= {w_step_sh[WIDTH-1], (w_step_sh == '0), w_step_c, 1'b0};
      end
    end
  end

  assign Rd           = rd_q;
  assign ShifterFlags = flags_q;

endmodule
`default_nettype wire
